time_display_scan: RTL and testbench

TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

---
 rtl/time_display_scan.sv | 168 ++++++++++++++++
 tb/tb_time_display_scan.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/time_display_scan.sv
// Multiplexed six-digit time display scanner for a 12-hour clock.
// Each frame captures a snapshot of the time inputs, converts it to BCD and
// scans the digits seconds-units (0) through hours-tens (5). Every digit is
// held for SCAN_DIV cycles. All outputs are registered and update together.
module time_display_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       am_pm,
  output logic [6:0] seg,
  output logic [5:0] dig_en,
  output logic       dp,
  output logic       pm_led,
  output logic       frame_start,
  output logic       err
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  // Scan counters and snapshot
  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_q;
  logic [3:0]  hrs_q, hrs_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic        ampm_q, ampm_d;
  logic        frame_go;

  // Registered outputs and their next values
  logic [6:0]  seg_q, seg_d;
  logic [5:0]  dig_en_q, dig_en_d;
  logic        dp_q, dp_d;
  logic        pm_led_q;
  logic        frame_start_q;
  logic        err_q, bad_d;

  logic [7:0]  hr_bcd, min_bcd, sec_bcd;
  logic [3:0]  nib;
  logic        blank;

  // Binary 0..63 to packed {tens, units} BCD.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // Seven-segment code, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // A snapshot is illegal if any field is outside the 12-hour clock range.
  function automatic logic illegal(input logic [3:0] h, input logic [5:0] m,
                                   input logic [5:0] s);
    return (h == 4'd0) || (h > 4'd12) || (m > 6'd59) || (s > 6'd59);
  endfunction

  // Next scan position; a frame start resets the scan and takes a new snapshot.
  always_comb begin
    frame_go = pend_q || ((presc_q == PRESC_LAST) && (idx_q == 3'd5));
    presc_d  = presc_q + 16'd1;
    idx_d    = idx_q;
    hrs_d    = hrs_q;
    min_d    = min_q;
    sec_d    = sec_q;
    ampm_d   = ampm_q;
    if (frame_go) begin
      presc_d = 16'd0;
      idx_d   = 3'd0;
      hrs_d   = hours;
      min_d   = minutes;
      sec_d   = seconds;
      ampm_d  = am_pm;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = 16'd0;
      idx_d   = idx_q + 3'd1;
    end
  end

  // Digit content for the next scan position, from the next snapshot.
  always_comb begin
    bad_d   = illegal(hrs_d, min_d, sec_d);
    hr_bcd  = to_bcd({2'b00, hrs_d});
    min_bcd = to_bcd(min_d);
    sec_bcd = to_bcd(sec_d);
    blank   = 1'b0;
    case (idx_d)
      3'd1:    nib = sec_bcd[7:4];
      3'd2:    nib = min_bcd[3:0];
      3'd3:    nib = min_bcd[7:4];
      3'd4:    nib = hr_bcd[3:0];
      3'd5: begin
        nib   = hr_bcd[7:4];
        blank = (hrs_d < 4'd10);
      end
      default: nib = sec_bcd[3:0];
    endcase
    if (bad_d)      seg_d = 7'h40;
    else if (blank) seg_d = 7'h00;
    else            seg_d = seg_code(nib);
    dig_en_d = 6'd1 << idx_d;
    dp_d     = !bad_d && ((idx_d == 3'd2) || (idx_d == 3'd4));
  end

  // Scan counter and snapshot state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b1;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      ampm_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= 1'b0;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ampm_q  <= ampm_d;
    end
  end

  // Output registers, cleared asynchronously so reset blanks the display at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q         <= '0;
      dig_en_q      <= '0;
      dp_q          <= 1'b0;
      pm_led_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dig_en_q      <= dig_en_d;
      dp_q          <= dp_d;
      pm_led_q      <= ampm_d;
      frame_start_q <= frame_go;
      err_q         <= bad_d;
    end
  end

  assign seg         = seg_q;
  assign dig_en      = dig_en_q;
  assign dp          = dp_q;
  assign pm_led      = pm_led_q;
  assign frame_start = frame_start_q;
  assign err         = err_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: directed time values plus randomized input
// changes, compared each cycle against a frame/digit reference model.
module tb_time_display_scan;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 6 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hours = 4'd12;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic       am_pm = 1'b0;
  logic [6:0] seg;
  logic [5:0] dig_en;
  logic       dp, pm_led, frame_start, err;

  time_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .seconds(seconds),
    .am_pm(am_pm), .seg(seg), .dig_en(dig_en), .dp(dp), .pm_led(pm_led),
    .frame_start(frame_start), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int e = 0;                      // index of the next edge since reset release
  int s_h = 0, s_m = 0, s_s = 0, s_p = 0;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input int h, input int m, input int s, input int p);
    hours   = 4'(h);
    minutes = 6'(m);
    seconds = 6'(s);
    am_pm   = 1'(p);
  endtask

  // One clock edge with rst high: update the model, then compare all outputs.
  task automatic step();
    int pos, d, val, exp_seg;
    bit bad;
    @(posedge clk);
    pos = e % FRAME;
    if (pos == 0) begin
      s_h = int'(hours); s_m = int'(minutes); s_s = int'(seconds); s_p = int'(am_pm);
    end
    e++;
    #1;
    d   = pos / SCAN_DIV;
    bad = (s_h == 0) || (s_h > 12) || (s_m > 59) || (s_s > 59);
    case (d)
      0: val = s_s % 10;
      1: val = s_s / 10;
      2: val = s_m % 10;
      3: val = s_m / 10;
      4: val = s_h % 10;
      default: val = s_h / 10;
    endcase
    if (bad)                    exp_seg = 'h40;
    else if (d == 5 && s_h < 10) exp_seg = 0;
    else                        exp_seg = int'(segtab[val]);
    check("seg",         32'(seg),         32'(exp_seg));
    check("dig_en",      32'(dig_en),      32'(1 << d));
    check("dp",          32'(dp),          32'(!bad && (d == 2 || d == 4)));
    check("pm_led",      32'(pm_led),      32'(s_p));
    check("frame_start", 32'(frame_start), 32'(pos == 0));
    check("err",         32'(err),         32'(bad));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_seg"},    32'(seg),         0);
    check({tag, "_dig_en"}, 32'(dig_en),      0);
    check({tag, "_dp"},     32'(dp),          0);
    check({tag, "_pm"},     32'(pm_led),      0);
    check({tag, "_fs"},     32'(frame_start), 0);
    check({tag, "_err"},    32'(err),         0);
  endtask

  task automatic run_to_pos(input int p);
    while ((e % FRAME) != p) step();
  endtask

  initial begin
    // Reset held with 12:00:00 AM applied
    set_in(12, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    e = 0;
    step();
    check("first_seg_3F", 32'(seg), 32'h3F);
    repeat (FRAME) step();          // frame_start must reappear exactly here
    check("refire_fs", 32'(frame_start), 1);

    // 9:05:07 AM
    set_in(9, 5, 7, 0);
    repeat (2 * FRAME) step();
    // 12:34:56 PM
    set_in(12, 34, 56, 1);
    repeat (2 * FRAME) step();

    // 11:59:59 AM, then 12:00:00 PM mid-frame
    set_in(11, 59, 59, 0);
    run_to_pos(0);
    repeat (FRAME) step();
    run_to_pos(10);
    set_in(12, 0, 0, 1);
    repeat (FRAME) step();

    // Illegal hour, then back to legal
    set_in(13, 0, 0, 0);
    repeat (2 * FRAME) step();
    set_in(1, 2, 3, 1);
    repeat (FRAME + 6) step();
    // Other illegal fields
    set_in(0, 10, 10, 0);
    repeat (FRAME) step();
    set_in(5, 60, 10, 0);
    repeat (FRAME) step();
    set_in(5, 10, 63, 1);
    repeat (FRAME) step();

    // Randomized inputs changing at arbitrary cycles
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 4) == 0)
          set_in($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63),
                 $urandom_range(0, 1));
        else
          set_in($urandom_range(1, 12), $urandom_range(0, 59), $urandom_range(0, 59),
                 $urandom_range(0, 1));
      end
      step();
    end

    // Reset asserted between edges at frame cycle 13
    set_in(10, 20, 30, 1);
    run_to_pos(0);
    run_to_pos(14);
    @(negedge clk);
    rst = 1'b0;
    #1 check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 check_zero("rst_low");
    @(negedge clk);
    rst = 1'b1;
    e = 0;
    step();
    check("restart_fs", 32'(frame_start), 1);
    check("restart_dig", 32'(dig_en), 1);
    repeat (2 * FRAME) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
